led_matrix_scan_ctrl: RTL and testbench
=======================================

// Module: led_matrix_scan_ctrl
// PURPOSE
//  Row-multiplexed scan controller for the 8x8 LED matrix on the GPIO headers.
//  Holds a double-buffered 8x8 framebuffer and drives one row at a time, with a
//  blanking gap between rows to stop ghosting. Frame swaps happen only at frame end.
//  Sits between the pattern logic (writes and swap requests) and the top-level pin
//  map. The top level applies the per-pin polarity: rows are inverted, cols are not.
// PARAMETERS
//  ROW_CYCLES    50000  clocks a row is driven (1 ms at 50 MHz); must be >= 1
//  BLANK_CYCLES  500    clocks all outputs are off before each row; must be >= 1
// PORTS
//  clock         in   1  system clock, 50 MHz
//  reset         in   1  asynchronous, active-high reset
//  enable        in   1  scan enable; 0 blanks the matrix and parks the scan
//  wr_en         in   1  write one back-buffer row this cycle
//  wr_row        in   3  back-buffer row index to write
//  wr_data       in   8  row data; bit c = column c lit
//  swap_req      in   1  one-cycle request: show the back buffer from the next frame
//  rows          out  8  one-hot active-high row drive, bit r = row r
//  cols          out  8  active-high column data for the driven row
//  row_idx       out  3  row currently scheduled
//  frame_start   out  1  one-cycle pulse when row 0 starts being driven
//  swap_pending  out  1  a swap has been requested but not yet done
//  swap_done     out  1  one-cycle pulse in the cycle after the buffers swap
// BEHAVIOUR
//  - All outputs are registered. On reset: state BLANK, row_idx=0, counter=0, rows=0,
//    cols=0, both buffers all 0, front select=0, swap_pending=0, pulses=0.
//  - FSM has two states, BLANK and DRIVE. The counter counts 0..N-1 in each state.
//  - BLANK: rows=0, cols=0. When the counter reaches BLANK_CYCLES-1, the next edge:
//    - enters DRIVE and clears the counter;
//    - loads cols <= front[row_idx] and rows <= 1<<row_idx.
//  - DRIVE: rows and cols stay fixed. Writes to the back buffer never change cols.
//    When the counter reaches ROW_CYCLES-1, the next edge:
//    - enters BLANK and clears rows and cols;
//    - sets row_idx <= row_idx+1, wrapping 7->0.
//  - Frame period is exactly 8*(ROW_CYCLES+BLANK_CYCLES) clocks.
//  - frame_start is high for the first DRIVE cycle of row 0.
//  - Swap event: the DRIVE->BLANK edge with row_idx=7 and swap_pending=1.
//    - On that edge the front select toggles and swap_pending clears.
//    - swap_done is high for the following cycle.
//    - The first row shown from the new buffer is row 0.
//  - swap_req sets swap_pending. A request while already pending is absorbed.
//    A request in the swap-event cycle re-arms pending for the next frame (set wins).
//  - wr_en writes back[wr_row] <= wr_data. The front buffer is never writable.
//    A write in the swap-event cycle goes to the pre-swap back buffer, so it is
//    visible in the new frame.
//  - enable=0 while running: next edge forces BLANK, row_idx=0, counter=0, rows=0,
//    cols=0. Writes, swap_req and swap_pending keep working; no swap occurs.
//    When enable returns to 1, scanning restarts with a full BLANK, then row 0.
//  - Reset mid-frame: the buffer contents are lost, and there is no partial frame
//    or glitch pulse after reset is released.
//  - At any instant at most one bit of rows is set.
// TESTING (bench uses ROW_CYCLES=4, BLANK_CYCLES=2)
//  - Reset release, enable=1, buffers zero:
//    - rows go 01,02,..,80 for 4 cycles each, separated by 2 cycles of 00;
//    - frame_start is high every 48 clocks;
//    - cols stay 00 throughout.
//  - Write back rows 0..7 with 8'h81,8'h42..; pulse swap_req mid-frame:
//    - swap_pending=1 until the row-7 end; swap_done then pulses once;
//    - in the next frame cols = 81,42,.. in sync with rows 01,02,..
//  - swap_req pulsed twice before frame end: exactly one swap_done.
//    swap_req coincident with the swap edge: a second swap_done one frame later.
//  - wr_en to row 3 while row 3 is driven from the front buffer: cols do not change.
//    The write to the back buffer appears only after a swap.
//  - enable dropped during row 5 DRIVE:
//    - rows and cols are 00 next cycle;
//    - on re-enable, 2 blank cycles, then rows=01, frame_start=1.
//  - reset asserted during row 4 DRIVE, async mid-cycle:
//    - rows and cols are 00 immediately;
//    - after release the pattern is the same as the first scenario.

Source files
------------

// File: rtl/led_matrix_scan_ctrl.sv
// ---------------------------------------------------------------------------
// led_matrix_scan_ctrl
//
// Row-multiplexed scan controller for an 8x8 LED matrix. It holds two 8x8
// framebuffers. The pattern logic writes the back buffer and requests swaps.
// The controller drives one row of the front buffer at a time and leaves a
// blanking gap before every row to stop ghosting. Buffer swaps only take
// effect at the end of a frame, so a frame is never torn. Per-pin polarity is
// applied by the top-level pin map.
//
// Ports
//   clock_i          system clock
//   reset_i          asynchronous, active-high reset
//   enable_i         scan enable; 0 blanks the matrix and parks the scan
//   wr_en_i          write one back-buffer row this cycle
//   wr_row_i[2:0]    back-buffer row to write
//   wr_data_i[7:0]   row data, bit c = column c lit
//   swap_req_i       one-cycle request to show the back buffer from next frame
//   rows_o[7:0]      one-hot active-high row drive, bit r = row r
//   cols_o[7:0]      active-high column data for the driven row
//   row_idx_o[2:0]   row currently scheduled
//   frame_start_o    one-cycle pulse on the first drive cycle of row 0
//   swap_pending_o   a swap has been requested but not yet performed
//   swap_done_o      one-cycle pulse in the cycle after the buffers swap
// ---------------------------------------------------------------------------
module led_matrix_scan_ctrl #(
  parameter int ROW_CYCLES   = 50000,  // clocks a row is driven, >= 1
  parameter int BLANK_CYCLES = 500     // clocks of blanking before each row, >= 1
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic       wr_en_i,
  input  logic [2:0] wr_row_i,
  input  logic [7:0] wr_data_i,
  input  logic       swap_req_i,
  output logic [7:0] rows_o,
  output logic [7:0] cols_o,
  output logic [2:0] row_idx_o,
  output logic       frame_start_o,
  output logic       swap_pending_o,
  output logic       swap_done_o
);

  // One counter serves both states, so it is sized for the longer phase.
  localparam int MAX_CYCLES = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  state_e           state_q,        state_d;
  logic [CNT_W-1:0] cnt_q,          cnt_d;
  logic [2:0]       row_idx_q,      row_idx_d;
  logic [7:0]       rows_q,         rows_d;
  logic [7:0]       cols_q,         cols_d;
  logic             front_sel_q,    front_sel_d;
  logic             swap_pending_q, swap_pending_d;
  logic             frame_start_q,  frame_start_d;
  logic             swap_done_q,    swap_done_d;

  // Framebuffers indexed [buffer][row]; front_sel_q picks the displayed one.
  logic [7:0] fb_q [2][8];

  logic [7:0] front_row;
  logic       back_sel;

  assign front_row = fb_q[front_sel_q][row_idx_q];
  assign back_sel  = ~front_sel_q;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + CNT_W'(1);
    row_idx_d      = row_idx_q;
    rows_d         = rows_q;
    cols_d         = cols_q;
    front_sel_d    = front_sel_q;
    swap_pending_d = swap_pending_q | swap_req_i;
    frame_start_d  = 1'b0;
    swap_done_d    = 1'b0;

    if (!enable_i) begin
      // Park the scan; the next enabled run starts with a full blank of row 0.
      state_d   = ST_BLANK;
      cnt_d     = '0;
      row_idx_d = 3'd0;
      rows_d    = 8'h00;
      cols_d    = 8'h00;
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d       = ST_DRIVE;
            cnt_d         = '0;
            rows_d        = 8'd1 << row_idx_q;
            // Column data is latched here, so back-buffer writes during the
            // drive phase can never disturb the row being shown.
            cols_d        = front_row;
            frame_start_d = (row_idx_q == 3'd0);
          end
        end
        ST_DRIVE: begin
          if (cnt_q == ROW_LAST) begin
            state_d   = ST_BLANK;
            cnt_d     = '0;
            rows_d    = 8'h00;
            cols_d    = 8'h00;
            row_idx_d = row_idx_q + 3'd1;
            // End of row 7 is the end of a frame: the only point a swap may
            // happen. A request in this same cycle re-arms for the next frame.
            if (row_idx_q == 3'd7 && swap_pending_q) begin
              front_sel_d    = ~front_sel_q;
              swap_pending_d = swap_req_i;
              swap_done_d    = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= ST_BLANK;
      cnt_q          <= '0;
      row_idx_q      <= 3'd0;
      rows_q         <= 8'h00;
      cols_q         <= 8'h00;
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      frame_start_q  <= 1'b0;
      swap_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      row_idx_q      <= row_idx_d;
      rows_q         <= rows_d;
      cols_q         <= cols_d;
      front_sel_q    <= front_sel_d;
      swap_pending_q <= swap_pending_d;
      frame_start_q  <= frame_start_d;
      swap_done_q    <= swap_done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Framebuffers
  // -------------------------------------------------------------------------
  // NOTE: the buffers are cleared by reset so the matrix never shows stale
  // or random content after reset; this keeps them in flops, not a RAM macro.
  // Only the back buffer is writable. In the swap cycle front_sel_q still
  // holds the old value, so that write lands in the buffer about to be shown.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          fb_q[b][r] <= 8'h00;
        end
      end
    end else if (wr_en_i) begin
      fb_q[back_sel][wr_row_i] <= wr_data_i;
    end
  end

  assign rows_o         = rows_q;
  assign cols_o         = cols_q;
  assign row_idx_o      = row_idx_q;
  assign frame_start_o  = frame_start_q;
  assign swap_pending_o = swap_pending_q;
  assign swap_done_o    = swap_done_q;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_matrix_scan_ctrl
//
// Directed bench for led_matrix_scan_ctrl with ROW_CYCLES=4, BLANK_CYCLES=2,
// so a row slot is 6 clocks and a frame is 48 clocks. Position in the frame
// is tracked by k, the number of enabled edges since the scan last restarted
// (reset release or the last disabled edge). Expected outputs are derived
// from k and a small model of the two buffers and the pending flag.
// ---------------------------------------------------------------------------
module tb_led_matrix_scan_ctrl;

  localparam int ROW_CYCLES   = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int SLOT         = ROW_CYCLES + BLANK_CYCLES;
  localparam int FRAME        = 8 * SLOT;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       enable_i;
  logic       wr_en_i;
  logic [2:0] wr_row_i;
  logic [7:0] wr_data_i;
  logic       swap_req_i;
  logic [7:0] rows_o;
  logic [7:0] cols_o;
  logic [2:0] row_idx_o;
  logic       frame_start_o;
  logic       swap_pending_o;
  logic       swap_done_o;

  int         checks;
  int         errors;
  int         k;
  int         done_cnt;
  logic       exp_pend;
  logic       exp_done;
  logic [7:0] model_front [8];
  logic [7:0] model_back  [8];
  logic [7:0] tbl         [8];
  logic [21:0] obs;

  always #5 clock_i = ~clock_i;

  led_matrix_scan_ctrl #(
    .ROW_CYCLES   (ROW_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .enable_i       (enable_i),
    .wr_en_i        (wr_en_i),
    .wr_row_i       (wr_row_i),
    .wr_data_i      (wr_data_i),
    .swap_req_i     (swap_req_i),
    .rows_o         (rows_o),
    .cols_o         (cols_o),
    .row_idx_o      (row_idx_o),
    .frame_start_o  (frame_start_o),
    .swap_pending_o (swap_pending_o),
    .swap_done_o    (swap_done_o)
  );

  // {rows, cols, row_idx, frame_start, swap_pending, swap_done}
  assign obs = {rows_o, cols_o, row_idx_o, frame_start_o, swap_pending_o, swap_done_o};

  // Expected output vector at the current frame position k.
  function automatic logic [21:0] exp_vec();
    int         p;
    int         slot;
    logic       drive;
    logic [7:0] r;
    logic [7:0] c;
    p     = k % FRAME;
    slot  = p / SLOT;
    drive = (p % SLOT) >= BLANK_CYCLES;
    r     = drive ? (8'd1 << slot) : 8'd0;
    c     = drive ? model_front[slot] : 8'd0;
    return {r, c, slot[2:0], (p == BLANK_CYCLES), exp_pend, exp_done};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      model_front[i] = 8'h00;
      model_back[i]  = 8'h00;
    end
    exp_pend = 1'b0;
    exp_done = 1'b0;
    k        = 0;
  endtask

  // Drive one clock of stimulus, then advance the model past that edge.
  task automatic cycle(input logic en, input logic req, input logic wr,
                       input logic [2:0] row, input logic [7:0] data);
    logic [7:0] tmp;
    enable_i   = en;
    swap_req_i = req;
    wr_en_i    = wr;
    wr_row_i   = row;
    wr_data_i  = data;
    @(posedge clock_i);
    #1;
    swap_req_i = 1'b0;
    wr_en_i    = 1'b0;
    if (wr) model_back[row] = data;
    exp_done = 1'b0;
    if (!en) begin
      k        = 0;
      exp_pend = exp_pend | req;
    end else begin
      k++;
      if ((k % FRAME) == 0 && exp_pend) begin
        for (int i = 0; i < 8; i++) begin
          tmp            = model_front[i];
          model_front[i] = model_back[i];
          model_back[i]  = tmp;
        end
        exp_done = 1'b1;
        exp_pend = req;
      end else begin
        exp_pend = exp_pend | req;
      end
    end
    if (swap_done_o) done_cnt++;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    #12;
    checks++;
    if (obs !== 22'd0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", obs, 22'd0);
    end
    enable_i = 1'b1;
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    model_clear();
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_blank_scan(input string name);
    for (int n = 0; n < 2 * FRAME; n++) begin
      cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL %s k=%0d got=%h exp=%h", name, k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_swap();
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 3'(i), tbl[i]);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL swap_write k=%0d got=%h exp=%h", k, obs, exp_vec());
      end
    end
    for (int n = 8; n < 2 * FRAME; n++) begin
      cycle(1'b1, n == 20, 1'b0, 3'd0, 8'h00);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL swap_frame k=%0d got=%h exp=%h", k, obs, exp_vec());
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL swap_done_count got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_double_req();
    done_cnt = 0;
    for (int n = 0; n < 2 * FRAME; n++) begin
      cycle(1'b1, (n == 9) || (n == 29), 1'b0, 3'd0, 8'h00);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL double_req k=%0d got=%h exp=%h", k, obs, exp_vec());
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL double_req_count got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_coincident();
    done_cnt = 0;
    for (int n = 0; n < 2 * FRAME; n++) begin
      cycle(1'b1, (n == 9) || (n == FRAME - 1), 1'b0, 3'd0, 8'h00);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL coincident k=%0d got=%h exp=%h", k, obs, exp_vec());
      end
    end
    checks++;
    if (done_cnt !== 2) begin
      errors++;
      $display("FAIL coincident_count got=%0d exp=2", done_cnt);
    end
  endtask

  task automatic test_write_during_drive();
    for (int n = 0; n < 3 * FRAME; n++) begin
      if (n == FRAME + 21)
        cycle(1'b1, 1'b0, 1'b1, 3'd3, 8'hC3);
      else if (n == FRAME + 40)
        cycle(1'b1, 1'b0, 1'b1, 3'd5, 8'h66);
      else
        cycle(1'b1, (n == 5) || (n == FRAME + 30), 1'b0, 3'd0, 8'h00);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL write_drive k=%0d got=%h exp=%h", k, obs, exp_vec());
      end
      if (n == FRAME + 21) begin
        checks++;
        if (cols_o !== 8'h18) begin
          errors++;
          $display("FAIL wr_no_effect got=%h exp=%h", cols_o, 8'h18);
        end
      end
    end
  endtask

  task automatic test_enable();
    for (int n = 0; n < 34; n++) begin
      cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL pre_disable k=%0d got=%h exp=%h", k, obs, exp_vec());
      end
    end
    // Row 5 is now being driven with non-zero columns.
    cycle(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    checks++;
    if (rows_o !== 8'h00 || cols_o !== 8'h00) begin
      errors++;
      $display("FAIL enable_drop got rows=%h cols=%h exp 00 00", rows_o, cols_o);
    end
    for (int d = 0; d < 5; d++) begin
      cycle(1'b0, d == 1, d == 2, 3'd0, 8'h99);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL disabled d=%0d got=%h exp=%h", d, obs, exp_vec());
      end
    end
    for (int n = 0; n < 2 * FRAME; n++) begin
      cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL reenable k=%0d got=%h exp=%h", k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_reset_midframe();
    for (int n = 0; n < 28; n++) begin
      cycle(1'b1, n == 3, 1'b0, 3'd0, 8'h00);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL pre_reset k=%0d got=%h exp=%h", k, obs, exp_vec());
      end
    end
    // Row 4 is driven with non-zero columns and a swap is pending.
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (obs !== 22'd0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", obs, 22'd0);
    end
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    model_clear();
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release2 got=%h exp=%h", obs, exp_vec());
    end
    test_blank_scan("post_reset");
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    done_cnt   = 0;
    enable_i   = 1'b0;
    wr_en_i    = 1'b0;
    wr_row_i   = 3'd0;
    wr_data_i  = 8'h00;
    swap_req_i = 1'b0;
    tbl        = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h3C, 8'h5A, 8'hA5, 8'hFF};
    model_clear();

    test_reset();
    test_blank_scan("blank_scan");
    test_swap();
    test_double_req();
    test_coincident();
    test_write_during_drive();
    test_enable();
    test_reset_midframe();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
